// File: rtl/timer_preset_ctrl.sv
// Preset controller for the shared system timer bus: arbitrates PPS and host preset requests,
// drives the tristate time bus during the preset strobe, and captures time snapshots.
module timer_preset_ctrl #(
    parameter int unsigned PRESET_CYCLES = 3
) (
    input  logic        clk,
    input  logic        n_rst,

    input  logic        pps_req,
    input  logic [15:0] pps_day,
    input  logic [26:0] pps_ms,
    input  logic [9:0]  pps_us,
    output logic        pps_ack,

    input  logic        host_req,
    input  logic [15:0] host_day,
    input  logic [26:0] host_ms,
    input  logic [9:0]  host_us,
    output logic        host_ack,

    input  logic        snap_req,
    output logic [15:0] snap_day,
    output logic [26:0] snap_ms,
    output logic [9:0]  snap_us,
    output logic        snap_valid,

    output logic        busy,
    output logic        tim_preset,
    inout  wire  [15:0] tim_day,
    inout  wire  [26:0] tim_ms,
    inout  wire  [9:0]  tim_us
);

    typedef struct packed {
        logic [15:0] day;
        logic [26:0] ms;
        logic [9:0]  us;
    } time_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHold,
        StDone
    } state_e;

    localparam logic [3:0] LastCnt = 4'(PRESET_CYCLES - 1);

    state_e     state_q, state_d;
    logic       win_host_q, win_host_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pps_pend_q, pps_pend_d;
    logic       host_pend_q, host_pend_d;
    logic       snap_pend_q, snap_pend_d;
    logic       snap_take;
    logic       load_drv;

    time_t      pps_val_q;
    time_t      host_val_q;
    time_t      drv_q;
    time_t      snap_q;
    logic       snap_valid_q;

    always_comb begin
        state_d     = state_q;
        win_host_d  = win_host_q;
        cnt_d       = cnt_q;
        pps_pend_d  = pps_pend_q | pps_req;
        host_pend_d = host_pend_q | host_req;
        snap_pend_d = snap_pend_q | snap_req;
        snap_take   = 1'b0;
        load_drv    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A waiting snapshot wins the idle cycle; the preset starts one cycle later.
                if (snap_pend_q || snap_req) begin
                    snap_take   = 1'b1;
                    snap_pend_d = 1'b0;
                end else if (pps_pend_q || pps_req) begin
                    state_d    = StLoad;
                    win_host_d = 1'b0;
                end else if (host_pend_q || host_req) begin
                    state_d    = StLoad;
                    win_host_d = 1'b1;
                end
            end
            StLoad: begin
                load_drv = 1'b1;
                cnt_d    = 4'd0;
                state_d  = StHold;
                // A fresh request from the winner in this cycle re-arms its pending flag.
                if (win_host_q) begin
                    host_pend_d = host_req;
                end else begin
                    pps_pend_d = pps_req;
                end
            end
            StHold: begin
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            win_host_q  <= 1'b0;
            cnt_q       <= 4'd0;
            pps_pend_q  <= 1'b0;
            host_pend_q <= 1'b0;
            snap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_host_q  <= win_host_d;
            cnt_q       <= cnt_d;
            pps_pend_q  <= pps_pend_d;
            host_pend_q <= host_pend_d;
            snap_pend_q <= snap_pend_d;
        end
    end

    // Latest request value always overwrites the latch; LOAD reads the value held before it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pps_val_q  <= '0;
            host_val_q <= '0;
            drv_q      <= '0;
        end else begin
            if (pps_req) begin
                pps_val_q <= '{day: pps_day, ms: pps_ms, us: pps_us};
            end
            if (host_req) begin
                host_val_q <= '{day: host_day, ms: host_ms, us: host_us};
            end
            if (load_drv) begin
                drv_q <= win_host_q ? host_val_q : pps_val_q;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap_take;
            if (snap_take) begin
                snap_q <= '{day: tim_day, ms: tim_ms, us: tim_us};
            end
        end
    end

    // Outputs decode straight from the state register so reset releases the bus at once.
    assign tim_preset = (state_q == StHold);
    assign busy       = (state_q != StIdle);
    assign pps_ack    = (state_q == StDone) && !win_host_q;
    assign host_ack   = (state_q == StDone) && win_host_q;

    assign tim_day = tim_preset ? drv_q.day : 16'bz;
    assign tim_ms  = tim_preset ? drv_q.ms  : 27'bz;
    assign tim_us  = tim_preset ? drv_q.us  : 10'bz;

    assign snap_day   = snap_q.day;
    assign snap_ms    = snap_q.ms;
    assign snap_us    = snap_q.us;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_timer_preset_ctrl.sv
// Scoreboard bench for timer_preset_ctrl: directed requests push expected events, a negedge
// monitor pops and compares presets, acks and snapshots against a behavioural system timer.
module tb_timer_preset_ctrl;

    localparam int P = 3;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        pps_req = 1'b0, host_req = 1'b0, snap_req = 1'b0;
    logic [15:0] pps_day = '0, host_day = '0;
    logic [26:0] pps_ms = '0, host_ms = '0;
    logic [9:0]  pps_us = '0, host_us = '0;
    logic        pps_ack, host_ack, snap_valid, busy, tim_preset;
    logic [15:0] snap_day;
    logic [26:0] snap_ms;
    logic [9:0]  snap_us;
    wire  [15:0] tim_day;
    wire  [26:0] tim_ms;
    wire  [9:0]  tim_us;

    logic [15:0] t_day = '0;
    logic [26:0] t_ms = '0;
    logic [9:0]  t_us = '0;

    always #5 clk = ~clk;

    timer_preset_ctrl #(.PRESET_CYCLES(P)) dut (
        .clk(clk), .n_rst(n_rst),
        .pps_req(pps_req), .pps_day(pps_day), .pps_ms(pps_ms), .pps_us(pps_us),
        .pps_ack(pps_ack),
        .host_req(host_req), .host_day(host_day), .host_ms(host_ms), .host_us(host_us),
        .host_ack(host_ack),
        .snap_req(snap_req), .snap_day(snap_day), .snap_ms(snap_ms), .snap_us(snap_us),
        .snap_valid(snap_valid),
        .busy(busy), .tim_preset(tim_preset),
        .tim_day(tim_day), .tim_ms(tim_ms), .tim_us(tim_us)
    );

    // System timer: drives the bus unless preset, loads from the bus while preset.
    assign tim_day = tim_preset ? 16'bz : t_day;
    assign tim_ms  = tim_preset ? 27'bz : t_ms;
    assign tim_us  = tim_preset ? 10'bz : t_us;

    always @(posedge clk) begin
        if (tim_preset) begin
            t_day <= tim_day;
            t_ms  <= tim_ms;
            t_us  <= tim_us;
        end else if (t_us == 10'd999) begin
            t_us <= '0;
            if (t_ms == 27'd86399999) begin
                t_ms  <= '0;
                t_day <= t_day + 16'd1;
            end else begin
                t_ms <= t_ms + 27'd1;
            end
        end else begin
            t_us <= t_us + 10'd1;
        end
    end

    typedef enum int {EvPreset, EvPpsAck, EvHostAck, EvSnap} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int          cyc;
        logic [15:0] day;
        logic [26:0] ms;
        logic [9:0]  us;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_e k, input int c, input logic [15:0] d,
                        input logic [26:0] m, input logic [9:0] u);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.day  = d;
        e.ms   = m;
        e.us   = u;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic [15:0] d, input logic [26:0] m,
                             input logic [9:0] u);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", longint'(k), longint'(e.kind));
            check("event_cycle", longint'(cyc), longint'(e.cyc));
            check("event_day", longint'(d), longint'(e.day));
            check("event_ms", longint'(m), longint'(e.ms));
            check("event_us", longint'(u), longint'(e.us));
        end
    endtask

    // Monitor
    bit          in_pulse = 1'b0;
    int          plen = 0;
    logic [15:0] cur_day;
    logic [26:0] cur_ms;
    logic [9:0]  cur_us;

    always @(negedge clk) begin
        if (!n_rst) begin
            in_pulse = 1'b0;
        end else begin
            if (tim_preset && !in_pulse) begin
                in_pulse = 1'b1;
                plen     = 0;
                cur_day  = tim_day;
                cur_ms   = tim_ms;
                cur_us   = tim_us;
                expect_ev(EvPreset, tim_day, tim_ms, tim_us);
            end
            if (tim_preset) begin
                plen++;
                check("bus_stable_us", longint'(tim_us), longint'(cur_us));
                check("bus_stable_day", longint'(tim_day), longint'(cur_day));
            end else begin
                if (in_pulse) begin
                    check("preset_len", longint'(plen), longint'(P));
                    in_pulse = 1'b0;
                end
                check("bus_released_us", longint'(tim_us), longint'(t_us));
                check("bus_released_ms", longint'(tim_ms), longint'(t_ms));
            end
            if (pps_ack) expect_ev(EvPpsAck, '0, '0, '0);
            if (host_ack) expect_ev(EvHostAck, '0, '0, '0);
            if (snap_valid) expect_ev(EvSnap, snap_day, snap_ms, snap_us);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; i < 1000 && cyc < c; i++) step();
    endtask

    int k;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_preset", longint'(tim_preset), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_pps_ack", longint'(pps_ack), 0);
        check("rst_host_ack", longint'(host_ack), 0);
        check("rst_snap_valid", longint'(snap_valid), 0);
        check("rst_snap_ms", longint'(snap_ms), 0);
        n_rst = 1'b1;
        step();
        step();

        // Host preset 5/1000/100, then snapshot shows the timer counting from it.
        k = cyc;
        host_day = 16'd5; host_ms = 27'd1000; host_us = 10'd100; host_req = 1'b1;
        push(EvPreset, k + 2, 16'd5, 27'd1000, 10'd100);
        push(EvHostAck, k + 2 + P, '0, '0, '0);
        step();
        host_req = 1'b0;
        check("busy_in_load", longint'(busy), 1);
        wait_until(k + 7);
        snap_req = 1'b1;
        push(EvSnap, k + 8, 16'd5, 27'd1000, 10'd102);
        step();
        snap_req = 1'b0;
        wait_until(k + 12);
        check("idle_busy", longint'(busy), 0);

        // Simultaneous PPS and host; snapshot requested during host DONE.
        k = cyc;
        pps_day = 16'd1; pps_ms = 27'd0; pps_us = 10'd0; pps_req = 1'b1;
        host_day = 16'd9; host_ms = 27'd9; host_us = 10'd9; host_req = 1'b1;
        push(EvPreset, k + 2, 16'd1, 27'd0, 10'd0);
        push(EvPpsAck, k + 5, '0, '0, '0);
        push(EvPreset, k + 8, 16'd9, 27'd9, 10'd9);
        push(EvHostAck, k + 11, '0, '0, '0);
        step();
        pps_req = 1'b0; host_req = 1'b0;
        wait_until(k + 11);
        snap_req = 1'b1;
        push(EvSnap, k + 13, 16'd9, 27'd9, 10'd10);
        step();
        snap_req = 1'b0;
        wait_until(k + 16);

        // Snapshot during HOLD is deferred to the first idle cycle.
        k = cyc;
        host_day = 16'd2; host_ms = 27'd3; host_us = 10'd4; host_req = 1'b1;
        push(EvPreset, k + 2, 16'd2, 27'd3, 10'd4);
        push(EvHostAck, k + 5, '0, '0, '0);
        step();
        host_req = 1'b0;
        wait_until(k + 3);
        snap_req = 1'b1;
        push(EvSnap, k + 7, 16'd2, 27'd3, 10'd5);
        step();
        snap_req = 1'b0;
        wait_until(k + 10);

        // Two host requests one cycle apart: A then B.
        k = cyc;
        host_day = 16'd7; host_ms = 27'd70; host_us = 10'd700; host_req = 1'b1;
        push(EvPreset, k + 2, 16'd7, 27'd70, 10'd700);
        push(EvHostAck, k + 5, '0, '0, '0);
        push(EvPreset, k + 8, 16'd8, 27'd80, 10'd800);
        push(EvHostAck, k + 11, '0, '0, '0);
        step();
        host_day = 16'd8; host_ms = 27'd80; host_us = 10'd800;
        step();
        host_req = 1'b0;
        wait_until(k + 14);

        // Snapshot and host request together in idle: snapshot first.
        k = cyc;
        host_day = 16'd1; host_ms = 27'd2; host_us = 10'd3; host_req = 1'b1;
        snap_req = 1'b1;
        push(EvSnap, k + 1, 16'd8, 27'd80, 10'd803);
        push(EvPreset, k + 3, 16'd1, 27'd2, 10'd3);
        push(EvHostAck, k + 6, '0, '0, '0);
        step();
        host_req = 1'b0; snap_req = 1'b0;
        wait_until(k + 9);

        // PPS requested twice while host is in service: queued, second value wins.
        k = cyc;
        host_day = 16'd4; host_ms = 27'd4; host_us = 10'd4; host_req = 1'b1;
        push(EvPreset, k + 2, 16'd4, 27'd4, 10'd4);
        push(EvHostAck, k + 5, '0, '0, '0);
        push(EvPreset, k + 8, 16'd7, 27'd7, 10'd7);
        push(EvPpsAck, k + 11, '0, '0, '0);
        step();
        host_req = 1'b0;
        wait_until(k + 2);
        pps_day = 16'd6; pps_ms = 27'd6; pps_us = 10'd6; pps_req = 1'b1;
        step();
        pps_day = 16'd7; pps_ms = 27'd7; pps_us = 10'd7;
        step();
        pps_req = 1'b0;
        wait_until(k + 14);

        // Reset during HOLD aborts the preset with no ack.
        k = cyc;
        host_day = 16'd3; host_ms = 27'd3; host_us = 10'd3; host_req = 1'b1;
        push(EvPreset, k + 2, 16'd3, 27'd3, 10'd3);
        step();
        host_req = 1'b0;
        wait_until(k + 3);
        check("hold_preset", longint'(tim_preset), 1);
        n_rst = 1'b0;
        #1;
        check("abort_preset", longint'(tim_preset), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_ack", longint'(host_ack), 0);
        check("abort_snap_day", longint'(snap_day), 0);
        check("abort_snap_us", longint'(snap_us), 0);
        step();
        step();
        n_rst = 1'b1;
        repeat (10) step();

        check("queue_empty", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_preset_ctrl.md
TIMER_PRESET_CTRL -- requirements
Module: timer_preset_ctrl

Interface
REQ-001 Parameter: PRESET_CYCLES, default 3, number of clk cycles tim_preset is held high (legal range 2..15).
REQ-002 Port: clk  input  1  system clock (60 MHz).
REQ-003 Port: n_rst  input  1  asynchronous, active-low reset.
REQ-004 Port: pps_req  input  1  single-cycle preset request from the PPS sync source.
REQ-005 Port: pps_day/pps_ms/pps_us  input  16/27/10  preset value for pps_req, sampled on the cycle pps_req is high.
REQ-006 Port: pps_ack  output  1  one-cycle pulse when the PPS preset has completed.
REQ-007 Port: host_req  input  1  single-cycle preset request from the host command path.
REQ-008 Port: host_day/host_ms/host_us  input  16/27/10  preset value for host_req, sampled on the cycle host_req is high.
REQ-009 Port: host_ack  output  1  one-cycle pulse when the host preset has completed.
REQ-010 Port: snap_req  input  1  single-cycle request to capture the current time.
REQ-011 Port: snap_day/snap_ms/snap_us  output  16/27/10  captured time, stable until the next capture.
REQ-012 Port: snap_valid  output  1  one-cycle pulse when the snap_* outputs are updated.
REQ-013 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 Port: tim_preset  output  1  preset strobe to the system timer.
REQ-015 Port: tim_day/tim_ms/tim_us  inout  16/27/10  shared system timer time bus.

Function
REQ-016 Bus ownership: the block SHALL drive tim_* only while tim_preset is high; otherwise it SHALL present high-Z. The timer drives the bus when tim_preset is low.
REQ-017 Pending flags: each req SHALL set a per-source pending flag and latch that source's value; a repeat req while pending and not yet in service SHALL overwrite the latched value.
REQ-018 FSM states: IDLE, LOAD, HOLD, DONE.
REQ-019 IDLE->LOAD when any flag is pending. Arbitration is fixed priority: PPS over host.
REQ-020 LOAD: copy the winner's value into the drive register, clear its pending flag, assert tim_preset on the following cycle. Lasts 1 cycle.
REQ-021 HOLD: tim_preset high and bus driven for exactly PRESET_CYCLES cycles, counted by a 4-bit counter.
REQ-022 DONE: tim_preset low, bus high-Z, winner's ack pulses for 1 cycle, then ->IDLE. A minimum 1-cycle gap SHALL separate back-to-back presets.
REQ-023 A req arriving during LOAD/HOLD/DONE for the source in service SHALL set pending again and be serviced afterward. A req for the other source SHALL be queued.
REQ-024 Simultaneous pps_req and host_req: PPS is serviced first, then host; both acks are delivered, host_ack at least PRESET_CYCLES+3 cycles after pps_ack.
REQ-025 Snapshot: when snap_req is seen (or is pending) and tim_preset is low and the FSM is in IDLE, the block SHALL register tim_* into snap_* and pulse snap_valid on the next cycle.
REQ-026 A snap_req arriving while busy SHALL be held pending and serviced in the first IDLE cycle. A snapshot pending in IDLE SHALL take precedence over starting a new preset in that cycle.
REQ-027 Latency with no contention: req at cycle N -> LOAD at N+1 -> tim_preset high N+2..N+1+PRESET_CYCLES -> ack at N+2+PRESET_CYCLES.

Reset
REQ-028 On n_rst low, asynchronously: FSM=IDLE, all pending flags cleared, tim_preset=0, tim_* high-Z, acks=0, snap_valid=0, snap_*=0, busy=0, counter=0.
REQ-029 Reset asserted mid-HOLD SHALL drop tim_preset and release the bus immediately. No ack is issued for the aborted preset.

Verification
REQ-030 host_req with day=5, ms=1000, us=100 (PRESET_CYCLES=3) -> tim_preset high 3 cycles, bus carries those values, host_ack 5 cycles after req; timer then counts from 5/1000/100.
REQ-031 pps_req and host_req in the same cycle (pps=1/0/0, host=9/9/9) -> PPS preset first with pps_ack, then host preset with host_ack; final timer value 9/9/9.
REQ-032 snap_req issued during HOLD -> snap_valid deferred until after DONE; snap_* equals the timer value following the preset, never high-Z or X.
REQ-033 n_rst pulsed low during HOLD -> tim_preset=0 within the same cycle, bus high-Z, no ack, busy=0.
REQ-034 Two host_reqs 1 cycle apart (values A then B) while idle -> first preset loads A and a second preset loads B; two host_acks are issued.
REQ-035 At every clock, the tim_* bus SHALL never be driven by this block while tim_preset=0 (assertion check).
